// File: rtl/risc_memory.sv
// risc_memory: single-port RAM for the VeriRisc CPU.
// Writes are synchronous to clk. Reads are combinational onto a shared
// bidirectional bus. The memory drives the bus only while rd is high.
module risc_memory #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic [AWIDTH-1:0] addr,
    inout  wire  [DWIDTH-1:0] data
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // Storage update: reset clears every word at once. A write is blocked
    // while rd is high, so the memory never captures the value it is
    // driving onto the bus itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr && !rd) begin
            mem[addr] <= data;
        end
    end

    // Bus drive: combinational read while rd is high, high-Z otherwise so
    // the CPU owns the bus. The contents are already zero during reset, so
    // a read under reset returns 0 without any extra gating.
    assign data = rd ? mem[addr] : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_risc_memory.sv
// Self-checking bench for risc_memory. A plain array keeps the expected
// contents; the bench drives the bus only while rd is low.
module tb_risc_memory;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic          drv_en;
    logic [DW-1:0] drv_val;
    wire  [DW-1:0] data;

    logic [DW-1:0] ref_mem [DEPTH];
    int            tests;
    int            fails;

    assign data = drv_en ? drv_val : {DW{1'bz}};

    risc_memory #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .rd   (rd),
        .addr (addr),
        .data (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Write one word over a full cycle, master driving the bus.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = a; drv_en = 1'b1; drv_val = d;
        @(negedge clk);
        wr = 1'b0; drv_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Read one word (master released) and compare against the model.
    task automatic do_read(input logic [AW-1:0] a, input string name);
        @(negedge clk);
        wr = 1'b0; drv_en = 1'b0; rd = 1'b1; addr = a;
        #1;
        tests++;
        if (data !== ref_mem[a]) begin
            fails++;
            $display("FAIL %s addr=%0d got=%h exp=%h", name, a, data, ref_mem[a]);
        end
        #1 rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] v;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; drv_en = 1'b0; drv_val = '0;
        model_clear();
        repeat (2) @(negedge clk);
        // read under reset returns 0
        rd = 1'b1; addr = 5'd9; #1;
        tests++;
        if (data !== 8'h00) begin
            fails++; $display("FAIL rst_read got=%h exp=00", data);
        end
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_read(5'd0,  "reset_addr0");
        do_read(5'd31, "reset_addr31");
        // bus release: with rd low the master's value must win cleanly
        @(negedge clk);
        rd = 1'b0; addr = 5'd0; drv_en = 1'b1;
        v = 8'h5A; drv_val = v; #1;
        tests++;
        if (data !== v) begin
            fails++; $display("FAIL bus_release got=%h exp=%h", data, v);
        end
        drv_en = 1'b0;
    endtask

    task automatic test_corners();
        do_write(5'd0, 8'hFF);
        do_write(5'd31, 8'h00);
        do_read(5'd0,  "corner_addr0");
        do_read(5'd31, "corner_addr31");
    endtask

    task automatic test_pattern();
        for (int i = 0; i < 31; i++) do_write(5'(31 - i), 8'(i));
        for (int i = 0; i < 31; i++) do_read(5'(31 - i), "pattern");
        tests++;
        if (ref_mem[16] !== 8'd15 || ref_mem[1] !== 8'd30) begin
            fails++; $display("FAIL pattern_model m16=%0d m1=%0d", ref_mem[16], ref_mem[1]);
        end
    endtask

    task automatic test_rd_wr_priority();
        @(negedge clk);
        drv_en = 1'b0; rd = 1'b1; wr = 1'b1; addr = 5'd5; #1;
        tests++;
        if (data !== 8'd26) begin
            fails++; $display("FAIL prio_before got=%h exp=%h", data, 8'd26);
        end
        @(posedge clk); #1;
        tests++;
        if (data !== 8'd26) begin
            fails++; $display("FAIL prio_after_edge got=%h exp=%h", data, 8'd26);
        end
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        do_read(5'd5, "prio_unchanged");
    endtask

    task automatic test_async_reset();
        do_write(5'd7, 8'hA5);
        do_read(5'd7, "pre_reset_a5");
        // pulse reset strictly between edges
        @(negedge clk); #2 rst = 1'b1; #2 rst = 1'b0;
        model_clear();
        do_read(5'd7, "async_reset_addr7");
        do_read(5'd16, "async_reset_addr16");
        // reset over an active write: reset must win
        do_write(5'd12, 8'h3C);
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = 5'd12; drv_en = 1'b1; drv_val = 8'hC3;
        #2 rst = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        wr = 1'b0; drv_en = 1'b0; rst = 1'b0;
        model_clear();
        do_read(5'd12, "reset_mid_write");
    endtask

    task automatic test_addr_change();
        do_write(5'd3, 8'h33);
        do_write(5'd4, 8'hC4);
        @(negedge clk);
        drv_en = 1'b0; wr = 1'b0; rd = 1'b1; addr = 5'd3; #1;
        tests++;
        if (data !== ref_mem[3]) begin
            fails++; $display("FAIL addr_change_a3 got=%h exp=%h", data, ref_mem[3]);
        end
        #1 addr = 5'd4; #1;
        tests++;
        if (data !== ref_mem[4]) begin
            fails++; $display("FAIL addr_change_a4 got=%h exp=%h", data, ref_mem[4]);
        end
        rd = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 0) do_write(a, DW'($urandom));
            else do_read(a, "random_read");
        end
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), "random_sweep");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_corners();
        test_pattern();
        test_rd_wr_priority();
        test_async_reset();
        test_addr_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/risc_memory.md
Name: risc_memory

Overview:
Single-port synchronous-write, asynchronous-read RAM with a shared bidirectional data bus, used as the VeriRisc CPU's instruction/data memory. The CPU drives the bus for writes. The memory drives the bus only while a read is requested and otherwise leaves it high-impedance. Depth is 2**AWIDTH words of DWIDTH bits.

Parameters:
AWIDTH, 5, address width; depth = 2**AWIDTH locations (32 by default).
DWIDTH, 8, data word width in bits.

Ports:
clk  input  1  clock; all writes occur on its rising edge.
rst  input  1  asynchronous, active-high reset.
wr  input  1  write request, sampled on rising clk.
rd  input  1  read request, combinational bus-drive enable.
addr  input  AWIDTH  word address for read and write.
data  inout  DWIDTH  shared data bus: input on writes, memory-driven output on reads.

Behaviour:
- Storage: array of 2**AWIDTH words of DWIDTH bits. Every address 0..2**AWIDTH-1 is valid; there is no out-of-range case.
- Reset:
  - rst=1 asynchronously clears every location to 0, without waiting for a clock edge.
  - While rst=1, writes are ignored.
  - While rst=1 with rd=1, the bus reads 0.
  - Reset asserted mid-write: the reset wins and the location is left at 0.
- Write:
  - On a rising clk edge with rst=0, wr=1 and rd=0, mem[addr] <= data.
  - Write latency is 1 edge; the new value is visible to a read immediately after that edge.
- Read:
  - data = mem[addr] whenever rd=1. This is purely combinational, with no clock latency.
  - A change to addr while rd=1 updates data within the same cycle.
- Bus release:
  - rd=0: memory drives all data bits to Z.
  - The external master owns the bus whenever rd=0.
- Simultaneous rd=1 and wr=1:
  - The read has priority: the memory drives the bus and no write occurs, so the memory never samples its own driven value.
- wr=0 and rd=0: no state change, bus high-Z.
- X or Z on data during a write: stored as-is. The master must not write an undriven bus.
- Contents persist indefinitely between reset assertions. No initial-file load.
- Read-during-write to the same address cannot occur, because writes require rd=0.

Test Plan:
1. Assert rst, release it, then read addr 0 and addr 31 with rd=1 -> data=8'h00 for both; with rd=0 -> data=8'hZZ.
2. Write addr 0 = 8'hFF, then addr 31 = 8'h00 (wr=1, rd=0, one cycle each), then read both (wr=0, rd=1, master bus released) -> data=8'hFF at addr 0 and 8'h00 at addr 31.
3. Write ascending data to descending addresses: addr 31..1 receives data 0..30 (addr 31=0, addr 30=1, ..., addr 1=30). Then read the same sequence back -> each read returns the matching value, e.g. addr 16 = 15 and addr 1 = 30.
4. Hold rd=1 and wr=1 at addr 5 (which holds 26) while applying a rising clk edge -> data reads 26 and mem[5] is unchanged afterwards.
5. Set addr 7 to 8'hA5, then assert rst asynchronously between clock edges, release it, and read addr 7 -> 8'h00. Also apply rst during an active write cycle -> the target location reads 0 afterwards.
6. With rd=1, change addr mid-cycle from 3 to 4 -> data switches combinationally to mem[4] before the next clock edge.
